// File: rtl/result_writeback_pkg.sv
// result_writeback_pkg
//   Constants shared by the block collector (read side) and result_writeback
//   (write side). Both sides use the same word order and key offset, so
//   ciphertext lands on top of the plaintext it came from.
//   - Word 0 of a block is bits [127:96]; word 3 is bits [31:0].
//   - RAM words 0..3 hold the key, so block addresses are offset by KEY_WORDS.
//   Optional feature macro used by the write side: WB_SKID_EN.
package result_writeback_pkg;

   localparam int BLK_W          = 128;
   localparam int WORD_W         = 32;
   localparam int WORDS_PER_BLK  = 4;
   localparam int WCNT_W         = 2;
   localparam int DEST_W         = 12;
   localparam int KEY_WORDS      = 4;
   localparam int BASE_OFFSET_DEF = KEY_WORDS;

   localparam logic [WCNT_W-1:0] LAST_WORD = 2'd3;

   // Writeback FSM encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Word idx of a 128-bit block, word 0 being the most significant.
   function automatic logic [WORD_W-1:0] wb_word(input logic [BLK_W-1:0] blk,
                                                 input logic [WCNT_W-1:0] idx);
      case (idx)
         2'd0:    return blk[127:96];
         2'd1:    return blk[95:64];
         2'd2:    return blk[63:32];
         default: return blk[31:0];
      endcase
   endfunction

endpackage

// File: rtl/result_writeback_if.sv
// result_writeback_if
//   Bus between the round datapath (master: offers result blocks and watches
//   the RAM write port) and result_writeback (slave).
//   Master -> slave : data_in[127:0], dest_address[11:0], valid
//   Slave -> master : busy, address[ADDR_W-1:0], data_out[31:0],
//                     write_enable, done, overrun, word_cnt[1:0]
interface result_writeback_if #(
   parameter int unsigned ADDR_W = 32
);
   import result_writeback_pkg::*;

   logic [BLK_W-1:0]  data_in;
   logic [DEST_W-1:0] dest_address;
   logic              valid;
   logic              busy;
   logic [ADDR_W-1:0] address;
   logic [WORD_W-1:0] data_out;
   logic              write_enable;
   logic              done;
   logic              overrun;
   logic [WCNT_W-1:0] word_cnt;

   modport master (
      output data_in, dest_address, valid,
      input  busy, address, data_out, write_enable, done, overrun, word_cnt
   );

   modport slave (
      input  data_in, dest_address, valid,
      output busy, address, data_out, write_enable, done, overrun, word_cnt
   );

endinterface

// File: rtl/result_writeback_skid_slot.sv
// wb_skid_slot
//   One-entry pending slot for a result block that arrives while the writer
//   is busy. Only instantiated when WB_SKID_EN is defined.
//   Ports: CLK, RST (async, active-high)
//          i_valid  : load i_data/i_addr into the slot
//          i_pop    : slot contents consumed this cycle
//          o_valid  : an entry is available to pop
//          o_full   : slot occupied (a new offer would be dropped)
//          o_data, o_addr : held entry
//   A fill and a pop in the same cycle leave the slot full with the new entry.
module wb_skid_slot
   import result_writeback_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              i_valid,
   input  logic [BLK_W-1:0]  i_data,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_pop,
   output logic              o_valid,
   output logic              o_full,
   output logic [BLK_W-1:0]  o_data,
   output logic [ADDR_W-1:0] o_addr
);

   logic              r_full;
   logic [BLK_W-1:0]  r_data;
   logic [ADDR_W-1:0] r_addr;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_full <= 1'b0;
         r_data <= '0;
         r_addr <= '0;
      end else if (i_valid) begin
         r_full <= 1'b1;
         r_data <= i_data;
         r_addr <= i_addr;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end

   assign o_valid = r_full;
   assign o_full  = r_full;
   assign o_data  = r_data;
   assign o_addr  = r_addr;

endmodule

// File: rtl/result_writeback.sv
// result_writeback
//   Serialises one 128-bit result block into four consecutive 32-bit RAM
//   writes at (dest_address + BASE_OFFSET) + 0..3, word 0 first.
//   Ports: CLK, RST (async, active-high), bus (result_writeback_if.slave):
//     in : data_in, dest_address, valid (one-cycle strobe)
//     out: busy, address, data_out, write_enable, done, overrun, word_cnt
//   All outputs are registered. The first word is on the RAM port in the
//   cycle right after valid; done pulses the cycle after the fourth word.
//   address/data_out hold their last values while write_enable is low.
//   Macro WB_SKID_EN: adds a one-entry pending slot (wb_skid_slot) so a
//   block offered while busy is kept rather than dropped; overrun then only
//   pulses when the slot is already occupied.
module result_writeback
   import result_writeback_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned BASE_OFFSET = BASE_OFFSET_DEF
) (
   input logic               CLK,
   input logic               RST,
   result_writeback_if.slave bus
);

   logic [1:0]        r_state;
   logic [BLK_W-1:0]  r_hold;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_dout;
   logic [WCNT_W-1:0] r_wcnt;
   logic              r_we;
   logic              r_done;
   logic              r_ovr;
   logic              r_busy;

   logic [1:0]        w_nxt_state;
   logic              w_start;
   logic              w_ovr;
   logic              w_busy_nxt;
   logic [ADDR_W-1:0] w_in_base;
   logic [BLK_W-1:0]  w_start_data;
   logic [ADDR_W-1:0] w_start_base;
   logic [WCNT_W-1:0] w_nidx;

   // Modulo 2^ADDR_W; no saturation on wrap.
   assign w_in_base = ADDR_W'(bus.dest_address) + ADDR_W'(BASE_OFFSET);
   assign w_nidx    = r_wcnt + 2'd1;

`ifdef WB_SKID_EN
   logic              w_fill;
   logic              w_pop;
   logic              w_slot_vld;
   logic              w_slot_full;
   logic [BLK_W-1:0]  w_slot_data;
   logic [ADDR_W-1:0] w_slot_addr;

   wb_skid_slot #(.ADDR_W(ADDR_W)) u_slot (
      .CLK     (CLK),
      .RST     (RST),
      .i_valid (w_fill),
      .i_data  (bus.data_in),
      .i_addr  (w_in_base),
      .i_pop   (w_pop),
      .o_valid (w_slot_vld),
      .o_full  (w_slot_full),
      .o_data  (w_slot_data),
      .o_addr  (w_slot_addr)
   );

   // A pending block always wins over a fresh offer; the fresh one refills.
   assign w_start_data = w_pop ? w_slot_data : bus.data_in;
   assign w_start_base = w_pop ? w_slot_addr : w_in_base;
   // Busy also covers a block waiting in the slot.
   assign w_busy_nxt   = (w_nxt_state == ST_WRITE) | w_fill | (w_slot_full & ~w_pop);
`else
   assign w_start_data = bus.data_in;
   assign w_start_base = w_in_base;
   assign w_busy_nxt   = (w_nxt_state == ST_WRITE);
`endif

   always_comb begin
      w_nxt_state = r_state;
      w_start     = 1'b0;
      w_ovr       = 1'b0;
`ifdef WB_SKID_EN
      w_fill      = 1'b0;
      w_pop       = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (bus.valid) begin
               w_start     = 1'b1;
               w_nxt_state = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (r_wcnt == LAST_WORD) w_nxt_state = ST_DONE;
`ifdef WB_SKID_EN
            if (bus.valid) begin
               if (w_slot_full) w_ovr  = 1'b1;
               else             w_fill = 1'b1;
            end
`else
            w_ovr = bus.valid;
`endif
         end
         ST_DONE: begin
`ifdef WB_SKID_EN
            if (w_slot_vld) begin
               w_start     = 1'b1;
               w_pop       = 1'b1;
               w_fill      = bus.valid;
               w_nxt_state = ST_WRITE;
            end else if (bus.valid) begin
               w_start     = 1'b1;
               w_nxt_state = ST_WRITE;
            end else begin
               w_nxt_state = ST_IDLE;
            end
`else
            if (bus.valid) begin
               w_start     = 1'b1;
               w_nxt_state = ST_WRITE;
            end else begin
               w_nxt_state = ST_IDLE;
            end
`endif
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_hold  <= '0;
         r_base  <= '0;
         r_addr  <= '0;
         r_dout  <= '0;
         r_wcnt  <= '0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_ovr   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_ovr   <= w_ovr;
         r_busy  <= w_busy_nxt;
         r_done  <= 1'b0;
         if (w_start) begin
            // Word 0 goes out on the very next cycle, straight from the input.
            r_hold <= w_start_data;
            r_base <= w_start_base;
            r_wcnt <= '0;
            r_we   <= 1'b1;
            r_addr <= w_start_base;
            r_dout <= wb_word(w_start_data, 2'd0);
         end else if (r_state == ST_WRITE) begin
            if (r_wcnt == LAST_WORD) begin
               // address/data_out/word_cnt keep the last word.
               r_we   <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_wcnt <= w_nidx;
               r_addr <= r_base + ADDR_W'(w_nidx);
               r_dout <= wb_word(r_hold, w_nidx);
            end
         end
      end
   end

   assign bus.busy         = r_busy;
   assign bus.address      = r_addr;
   assign bus.data_out     = r_dout;
   assign bus.write_enable = r_we;
   assign bus.done         = r_done;
   assign bus.overrun      = r_ovr;
   assign bus.word_cnt     = r_wcnt;

endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback
//   Directed bench for result_writeback: reset values, single block,
//   back-to-back blocks, overrun (or skid slot when WB_SKID_EN is defined),
//   reset mid-transfer and 12-bit address wrap (second instance, ADDR_W=12).
module tb_result_writeback;
   import result_writeback_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   result_writeback_if #(.ADDR_W(32)) bus ();
   result_writeback_if #(.ADDR_W(12)) bus12 ();

   result_writeback #(.ADDR_W(32), .BASE_OFFSET(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   result_writeback #(.ADDR_W(12), .BASE_OFFSET(4)) dut12 (
      .CLK (CLK),
      .RST (RST),
      .bus (bus12)
   );

   int total  = 0;
   int passed = 0;
   int failed = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [127:0] blk, input logic [11:0] dest);
      bus.valid        = 1'b1;
      bus.data_in      = blk;
      bus.dest_address = dest;
      tick();
      bus.valid        = 1'b0;
   endtask

   task automatic expw(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] c);
      chk({tag, "_we"},   bus.write_enable, 1);
      chk({tag, "_addr"}, bus.address, a);
      chk({tag, "_data"}, bus.data_out, d);
      chk({tag, "_wcnt"}, bus.word_cnt, c);
      chk({tag, "_busy"}, bus.busy, 1);
   endtask

   // Checks words 0..3 of blk, one per cycle; returns in the word-3 cycle.
   task automatic expblk(input string tag, input logic [127:0] blk, input logic [31:0] base);
      logic [127:0] b;
      b = blk;
      for (int i = 0; i < 4; i++) begin
         expw($sformatf("%s_w%0d", tag, i), base + i, b[127 - 32*i -: 32], 2'(i));
         if (i < 3) tick();
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_we"},   bus.write_enable, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_ovr"},  bus.overrun, 0);
      chk({tag, "_wcnt"}, bus.word_cnt, 0);
      chk({tag, "_addr"}, bus.address, 0);
      chk({tag, "_data"}, bus.data_out, 0);
   endtask

   localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] BLK_B = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
   localparam logic [127:0] BLK_C = 128'h0C0C0C01_0C0C0C02_0C0C0C03_0C0C0C04;
   localparam logic [127:0] BLK_D = 128'h0D0D0D01_0D0D0D02_0D0D0D03_0D0D0D04;
   localparam logic [127:0] BLK_E = 128'h0E0E0E01_0E0E0E02_0E0E0E03_0E0E0E04;
   localparam logic [127:0] BLK_F = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] BLK_G = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

   initial begin
      bus.valid = 1'b0;   bus.data_in = '0;   bus.dest_address = '0;
      bus12.valid = 1'b0; bus12.data_in = '0; bus12.dest_address = '0;

      // Reset state
      #1 RST = 1'b1;
      #1 chk_all_zero("rst");
      @(posedge CLK); #1;
      RST = 1'b0;
      tick();

      // Single block at 0x010 -> base 0x014
      send(BLK_A, 12'h010);
      expblk("single", BLK_A, 32'h14);
      tick();
      chk("single_done", bus.done, 1);
      chk("single_we_off", bus.write_enable, 0);
      chk("single_busy_off", bus.busy, 0);
      chk("single_addr_hold", bus.address, 32'h17);
      chk("single_data_hold", bus.data_out, 32'hCCDDEEFF);
      tick();
      chk("single_done_pulse", bus.done, 0);
      chk("single_idle_we", bus.write_enable, 0);

      // Back-to-back: second valid in the DONE cycle
      send(BLK_A, 12'h020);
      expblk("b2b_a", BLK_A, 32'h24);
      tick();
      chk("b2b_a_done", bus.done, 1);
      send(BLK_B, 12'h030);
      chk("b2b_no_ovr", bus.overrun, 0);
      chk("b2b_done_clr", bus.done, 0);
      expblk("b2b_b", BLK_B, 32'h34);
      tick();
      chk("b2b_b_done", bus.done, 1);
      chk("b2b_b_ovr", bus.overrun, 0);
      tick();
      chk("b2b_idle_busy", bus.busy, 0);

`ifdef WB_SKID_EN
      // Skid: valids at E0 and E2 both written, third at E3 dropped
      send(BLK_C, 12'h040);
      expw("skid_c_w0", 32'h44, 32'h0C0C0C01, 2'd0);
      tick();
      expw("skid_c_w1", 32'h45, 32'h0C0C0C02, 2'd1);
      send(BLK_D, 12'h050);
      chk("skid_fill_no_ovr", bus.overrun, 0);
      expw("skid_c_w2", 32'h46, 32'h0C0C0C03, 2'd2);
      send(BLK_E, 12'h060);
      chk("skid_ovr", bus.overrun, 1);
      expw("skid_c_w3", 32'h47, 32'h0C0C0C04, 2'd3);
      tick();
      chk("skid_c_done", bus.done, 1);
      chk("skid_c_busy", bus.busy, 1);
      chk("skid_ovr_pulse", bus.overrun, 0);
      tick();
      expblk("skid_d", BLK_D, 32'h54);
      tick();
      chk("skid_d_done", bus.done, 1);
      chk("skid_d_busy", bus.busy, 0);
      tick();
      chk("skid_end_we", bus.write_enable, 0);
      chk("skid_end_done", bus.done, 0);
`else
      // Overrun: valid at cycle 2 of WRITE is dropped
      send(BLK_C, 12'h040);
      expw("ovr_c_w0", 32'h44, 32'h0C0C0C01, 2'd0);
      tick();
      expw("ovr_c_w1", 32'h45, 32'h0C0C0C02, 2'd1);
      send(BLK_D, 12'h050);
      chk("ovr_pulse", bus.overrun, 1);
      expw("ovr_c_w2", 32'h46, 32'h0C0C0C03, 2'd2);
      tick();
      chk("ovr_pulse_end", bus.overrun, 0);
      expw("ovr_c_w3", 32'h47, 32'h0C0C0C04, 2'd3);
      tick();
      chk("ovr_c_done", bus.done, 1);
      tick();
      chk("ovr_no_d_we", bus.write_enable, 0);
      chk("ovr_no_d_busy", bus.busy, 0);
      chk("ovr_addr_hold", bus.address, 32'h47);
`endif

      // Reset after two words
      send(BLK_F, 12'h100);
      expw("rstw_w0", 32'h104, 32'h11111111, 2'd0);
      tick();
      expw("rstw_w1", 32'h105, 32'h22222222, 2'd1);
      #2 RST = 1'b1;
      #1 chk_all_zero("rstw_async");
      @(posedge CLK); #1;
      RST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("rstw_quiet%0d_we", i), bus.write_enable, 0);
         chk($sformatf("rstw_quiet%0d_done", i), bus.done, 0);
      end
      send(BLK_G, 12'h000);
      expblk("rstw_g", BLK_G, 32'h4);
      tick();
      chk("rstw_g_done", bus.done, 1);
      tick();

      // 12-bit address wrap: 0xFFE + 4 -> 0x002
      bus12.valid        = 1'b1;
      bus12.data_in      = BLK_A;
      bus12.dest_address = 12'hFFE;
      tick();
      bus12.valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wrap_w%0d_we", i), bus12.write_enable, 1);
         chk($sformatf("wrap_w%0d_addr", i), bus12.address, 64'(12'h002 + i));
         if (i < 3) tick();
      end
      chk("wrap_w3_data", bus12.data_out, 32'hCCDDEEFF);
      tick();
      chk("wrap_done", bus12.done, 1);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
